// File: rtl/argmax_pkg.sv
// Shared types and helpers for the streaming argmax: the top-2 record carried through the
// lane reduction tree and accumulator, and the signed/unsigned score comparison.
package argmax_pkg;

    localparam int MAX_IDX_W   = 16;
    localparam int MAX_SCORE_W = 32;

    // Fields are sized for the widest configuration; instances use the low SCORE_W/IDX_W bits.
    typedef struct packed {
        logic                   valid;
        logic                   has_second;
        logic [MAX_IDX_W-1:0]   idx;
        logic [MAX_SCORE_W-1:0] best;
        logic [MAX_SCORE_W-1:0] second;
    } top2_t;

    localparam top2_t TOP2_EMPTY = '0;

    // a >= b over the low w bits; signed order is unsigned order with the sign bit inverted.
    function automatic logic score_ge(input logic [MAX_SCORE_W-1:0] a,
                                      input logic [MAX_SCORE_W-1:0] b,
                                      input int                     w,
                                      input bit                     signed_mode);
        logic [MAX_SCORE_W-1:0] one;
        logic [MAX_SCORE_W-1:0] mask;
        logic [MAX_SCORE_W-1:0] flip;
        one  = {{(MAX_SCORE_W-1){1'b0}}, 1'b1};
        mask = (w >= MAX_SCORE_W) ? '1 : ((one << w) - one);
        flip = signed_mode ? (one << (w - 1)) : '0;
        return ((a & mask) ^ flip) >= ((b & mask) ^ flip);
    endfunction

endpackage

// File: rtl/argmax_stream_if.sv
// Score input stream, result output stream and frame flush for argmax_stream.
interface argmax_stream_if #(
    parameter int NUM_CLASSES = 10,
    parameter int SCORE_W     = 8,
    parameter int LANES       = 2
);
    localparam int IDX_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;

    logic                     flush;
    logic                     s_valid;
    logic                     s_ready;
    logic [LANES*SCORE_W-1:0] s_score;
    logic                     m_valid;
    logic                     m_ready;
    logic [IDX_W-1:0]         m_index;
    logic [SCORE_W-1:0]       m_max;
    logic [SCORE_W:0]         m_margin;

    modport master (
        output flush, s_valid, s_score, m_ready,
        input  s_ready, m_valid, m_index, m_max, m_margin
    );

    modport slave (
        input  flush, s_valid, s_score, m_ready,
        output s_ready, m_valid, m_index, m_max, m_margin
    );

endinterface

// File: rtl/argmax_stream_top2_merge.sv
// Combinational merge of two top-2 records; 'a' always covers the lower class indices,
// so it wins ties.
module top2_merge
    import argmax_pkg::*;
#(
    parameter int SCORE_W = 8,
    parameter bit SIGNED  = 1'b0
) (
    input  top2_t a,
    input  top2_t b,
    output top2_t y
);

    always_comb begin
        y = a;
        if (!a.valid) begin
            y = b;
        end else if (b.valid) begin
            y.valid      = 1'b1;
            y.has_second = 1'b1;
            if (score_ge(a.best, b.best, SCORE_W, SIGNED)) begin
                y.idx    = a.idx;
                y.best   = a.best;
                y.second = (a.has_second && score_ge(a.second, b.best, SCORE_W, SIGNED))
                           ? a.second : b.best;
            end else begin
                y.idx    = b.idx;
                y.best   = b.best;
                y.second = (b.has_second && score_ge(b.second, a.best, SCORE_W, SIGNED))
                           ? b.second : a.best;
            end
        end
    end

endmodule

// File: rtl/argmax_stream.sv
// Streaming argmax over NUM_CLASSES scores delivered LANES per beat; reports winning index,
// winning score and the margin to the runner-up.
module argmax_stream
    import argmax_pkg::*;
#(
    parameter int NUM_CLASSES = 10,
    parameter int SCORE_W     = 8,
    parameter int LANES       = 2,
    parameter bit SIGNED      = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    argmax_stream_if.slave  bus
);

    localparam int IDX_W  = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
    localparam int BEATS  = (NUM_CLASSES + LANES - 1) / LANES;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LEVELS = $clog2(LANES);
    localparam int LEAVES = 1 << LEVELS;

    genvar gi, gj;

    logic [CNT_W-1:0]   beat_cnt_reg;
    top2_t              acc_reg;
    logic               m_valid_reg;
    logic [IDX_W-1:0]   index_reg;
    logic [SCORE_W-1:0] max_reg;
    logic [SCORE_W:0]   margin_reg;

    logic               last_beat;
    logic               beat_accept;
    top2_t              lane_top2;
    top2_t              acc_base;
    top2_t              acc_next;
    logic [SCORE_W-1:0] win_best;
    logic [SCORE_W-1:0] win_second;
    logic [SCORE_W:0]   margin_next;
    logic               unused_bits;

    // Level 0 holds one record per lane (padded to a power of two); each level halves it.
    for (gi = 0; gi <= LEVELS; gi++) begin : g_lvl
        localparam int W = LEAVES >> gi;
        top2_t nd [W];
        if (gi == 0) begin : g_leaf
            for (gj = 0; gj < W; gj++) begin : g_lane
                if (gj < LANES) begin : g_real
                    int cls;
                    assign cls = int'(beat_cnt_reg) * LANES + gj;
                    // Classes past the end on the last beat are padding and never compete.
                    assign nd[gj] = '{valid:      (cls < NUM_CLASSES),
                                      has_second: 1'b0,
                                      idx:        MAX_IDX_W'(cls),
                                      best:       MAX_SCORE_W'(bus.s_score[gj*SCORE_W +: SCORE_W]),
                                      second:     '0};
                end else begin : g_pad
                    assign nd[gj] = TOP2_EMPTY;
                end
            end
        end else begin : g_merge
            for (gj = 0; gj < W; gj++) begin : g_node
                top2_merge #(.SCORE_W(SCORE_W), .SIGNED(SIGNED)) u_merge (
                    .a (g_lvl[gi-1].nd[2*gj]),
                    .b (g_lvl[gi-1].nd[2*gj+1]),
                    .y (nd[gj])
                );
            end
        end
    end

    assign lane_top2 = g_lvl[LEVELS].nd[0];

    // On beat 0 the stale accumulator is masked so the lane result loads directly.
    assign acc_base = (beat_cnt_reg == '0) ? TOP2_EMPTY : acc_reg;

    top2_merge #(.SCORE_W(SCORE_W), .SIGNED(SIGNED)) u_acc_merge (
        .a (acc_base),
        .b (lane_top2),
        .y (acc_next)
    );

    assign win_best    = acc_next.best[SCORE_W-1:0];
    assign win_second  = acc_next.second[SCORE_W-1:0];
    assign margin_next = {SIGNED && win_best[SCORE_W-1], win_best}
                       - {SIGNED && win_second[SCORE_W-1], win_second};
    assign unused_bits = ^acc_next;

    assign last_beat   = (beat_cnt_reg == CNT_W'(BEATS - 1));
    assign bus.s_ready = !(last_beat && m_valid_reg && !bus.m_ready);
    assign beat_accept = bus.s_valid && bus.s_ready && !bus.flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt_reg <= '0;
            acc_reg      <= TOP2_EMPTY;
            m_valid_reg  <= 1'b0;
            index_reg    <= '0;
            max_reg      <= '0;
            margin_reg   <= '0;
        end else begin
            if (bus.flush) begin
                beat_cnt_reg <= '0;
                acc_reg      <= TOP2_EMPTY;
            end else if (beat_accept) begin
                acc_reg      <= acc_next;
                beat_cnt_reg <= last_beat ? '0 : beat_cnt_reg + 1'b1;
            end

            // A final beat landing with the consume reloads the output without a bubble.
            if (beat_accept && last_beat) begin
                m_valid_reg <= 1'b1;
                index_reg   <= acc_next.idx[IDX_W-1:0];
                max_reg     <= win_best;
                margin_reg  <= margin_next;
            end else if (bus.m_ready) begin
                m_valid_reg <= 1'b0;
            end
        end
    end

    assign bus.m_valid  = m_valid_reg;
    assign bus.m_index  = index_reg;
    assign bus.m_max    = max_reg;
    assign bus.m_margin = margin_reg;

endmodule
